mux_sel_rr_arbiter: RTL and testbench

- Upstream control stage for the team's 4:1 data mux: owns the mux select pair (s0, s1).
- Four requesters compete for the shared mux output; the block grants one at a time in round-robin order.
- It drives s0/s1 to route the granted channel and holds the selection stable for a bounded dwell.
- A one-cycle guard gap between grants keeps select changes from overlapping an active transfer.

---
 rtl/mux_sel_rr_arbiter_pkg.sv | 37 +++
 rtl/mux_sel_rr_arbiter_if.sv | 34 +++
 rtl/mux_sel_rr_arbiter_rr_pick.sv | 28 ++
 rtl/mux_sel_rr_arbiter.sv | 106 ++++++++++
 tb/tb_mux_sel_rr_arbiter.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/mux_sel_rr_arbiter_pkg.sv
// Shared types and constants for the mux-select round-robin arbiter.
// Combinational helpers only; no latency, no flow control of its own.
package mux_sel_pkg;

    localparam int NUM_CH = 4;
    localparam int IDX_W  = 2;

    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [NUM_CH-1:0] ch_vec_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_GAP    = 2'd2;

    // Select pair packed as {s0, s1}; s0 is the MSB of the channel index.
    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    function automatic logic [1:0] idx_to_sel(idx_t idx);
        case (idx)
            2'd0:    return SEL_A;
            2'd1:    return SEL_B;
            2'd2:    return SEL_C;
            default: return SEL_D;
        endcase
    endfunction

    function automatic ch_vec_t idx_to_onehot(idx_t idx);
        ch_vec_t v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_sel_rr_arbiter_if.sv
// Request/grant bundle between the four consumers and the mux-select arbiter.
// Pure wiring; no latency; the arbiter side is the slave modport.
interface mux_sel_rr_arbiter_if;
    import mux_sel_pkg::*;

    ch_vec_t req;
    logic    done;
    logic    s0;
    logic    s1;
    logic    sel_valid;
    ch_vec_t grant;
    logic    busy;

    modport master (
        output req,
        output done,
        input  s0,
        input  s1,
        input  sel_valid,
        input  grant,
        input  busy
    );

    modport slave (
        input  req,
        input  done,
        output s0,
        output s1,
        output sel_valid,
        output grant,
        output busy
    );

endinterface

// File: rtl/mux_sel_rr_arbiter_rr_pick.sv
// Round-robin pick: first set request scanning upward from last_ptr+1 with wrap.
// Purely combinational; zero latency, no backpressure.
module rr_pick
    import mux_sel_pkg::*;
(
    input  ch_vec_t req,
    input  idx_t    last_ptr,
    output logic    found,
    output idx_t    idx
);

    idx_t cand;

    // Scan from farthest to nearest so the nearest set request wins last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            cand = last_ptr + IDX_W'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin owner of the 4:1 mux select pair; all outputs registered, grant 1 cycle after req.
// Grant held until done or req drop (plus HOLD_CYCLES dwell limit with MUX_SEL_TIMEOUT_EN), then 1-cycle GAP.
module mux_sel_rr_arbiter
    import mux_sel_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux_sel_rr_arbiter_if.slave  bus
);

    generate
        if (HOLD_CYCLES < 1 || ((HOLD_CYCLES - 1) >> CNT_W) != 0) begin : g_bad_hold
            $error("HOLD_CYCLES-1 must fit in CNT_W bits and HOLD_CYCLES must be >= 1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

    logic [1:0]       state;
    idx_t             cur;
    idx_t             last_ptr;
    logic [CNT_W-1:0] cnt;
    ch_vec_t          grant_r;
    logic [1:0]       sel_r;
    logic             sel_valid_r;
    logic             busy_r;

    logic             pick_found;
    idx_t             pick_idx;
    logic             timeout;
    logic             exit_now;

    rr_pick u_rr_pick (
        .req      (bus.req),
        .last_ptr (last_ptr),
        .found    (pick_found),
        .idx      (pick_idx)
    );

`ifdef MUX_SEL_TIMEOUT_EN
    assign timeout = (cnt == CNT_MAX);
`else
    assign timeout = 1'b0;
`endif

    // done and a req drop on the same edge collapse into a single exit.
    assign exit_now = bus.done || !bus.req[cur] || timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cur         <= '0;
            last_ptr    <= 2'd3;
            cnt         <= '0;
            grant_r     <= '0;
            sel_r       <= SEL_A;
            sel_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        state       <= ST_ACTIVE;
                        cur         <= pick_idx;
                        cnt         <= '0;
                        grant_r     <= idx_to_onehot(pick_idx);
                        sel_r       <= idx_to_sel(pick_idx);
                        sel_valid_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (exit_now) begin
                        state       <= ST_GAP;
                        last_ptr    <= cur;
                        grant_r     <= '0;
                        sel_valid_r <= 1'b0;
                    end
                end
                ST_GAP: begin
                    state  <= ST_IDLE;
                    busy_r <= 1'b0;
                end
                default: begin
                    state       <= ST_IDLE;
                    grant_r     <= '0;
                    sel_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s0        = sel_r[1];
    assign bus.s1        = sel_r[0];
    assign bus.sel_valid = sel_valid_r;
    assign bus.grant     = grant_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Directed bench for mux_sel_rr_arbiter; covers both MUX_SEL_TIMEOUT_EN builds.
module tb_mux_sel_rr_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mux_sel_rr_arbiter_if bus ();

    mux_sel_rr_arbiter #(
        .HOLD_CYCLES (4),
        .CNT_W       (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Observed vector: {grant[3:0], s0, s1, sel_valid, busy}
    task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] sel,
                              input logic sv, input logic b);
        logic [7:0] obs;
        logic [7:0] exp_v;
        obs   = {bus.grant, bus.s0, bus.s1, bus.sel_valid, bus.busy};
        exp_v = {g, sel, sv, b};
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b (grant,s0,s1,sel_valid,busy)", tag, obs, exp_v);
        end
    endtask

    // Invariants sampled every falling edge while out of reset.
    logic       prev_sv;
    logic [1:0] prev_sel;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            assert ($onehot0(bus.grant) && (bus.sel_valid === |bus.grant)) else begin
                errors++;
                $error("FAIL inv_grant grant=%b sel_valid=%b", bus.grant, bus.sel_valid);
            end
            for (int i = 0; i < 4; i++) begin
                if (bus.grant[i] === 1'b1) begin
                    checks++;
                    assert ({bus.s0, bus.s1} === 2'(i)) else begin
                        errors++;
                        $error("FAIL inv_sel_map sel=%b required=%0d", {bus.s0, bus.s1}, i);
                    end
                end
            end
            if (prev_sv === 1'b1 && bus.sel_valid === 1'b1) begin
                checks++;
                assert ({bus.s0, bus.s1} === prev_sel) else begin
                    errors++;
                    $error("FAIL inv_sel_stable sel=%b required=%b", {bus.s0, bus.s1}, prev_sel);
                end
            end
            prev_sv  = bus.sel_valid;
            prev_sel = {bus.s0, bus.s1};
        end else begin
            prev_sv = 1'b0;
        end
    end

    initial begin
        logic [1:0] idx;
        rst_n    = 1'b0;
        bus.req  = 4'b1111;
        bus.done = 1'b0;
        prev_sv  = 1'b0;
        prev_sel = 2'b00;

        // Reset holds everything low despite active requests
        repeat (2) @(negedge clk);
        expect_out("reset_state", 4'b0000, 2'b00, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1 expect_out("post_release_no_edge", 4'b0000, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        expect_out("first_grant_ch0", 4'b0001, 2'b00, 1'b1, 1'b1);
        bus.req = 4'b0000;
        @(negedge clk);
        expect_out("first_gap", 4'b0000, 2'b00, 1'b0, 1'b1);
        @(negedge clk);
        expect_out("first_idle", 4'b0000, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        expect_out("idle_no_req", 4'b0000, 2'b00, 1'b0, 1'b0);

        // Single request on channel c, done on third ACTIVE cycle
        bus.req = 4'b0100;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            expect_out($sformatf("single_c_cyc%0d", c), 4'b0100, 2'b10, 1'b1, 1'b1);
        end
        bus.done = 1'b1;
        @(negedge clk);
        expect_out("single_gap", 4'b0000, 2'b10, 1'b0, 1'b1);
        bus.done = 1'b0;
        bus.req  = 4'b0000;
        @(negedge clk);
        expect_out("single_idle", 4'b0000, 2'b10, 1'b0, 1'b0);

        // last_ptr=2, so channel 3 beats channel 0; then withdraw in cycle 2
        bus.req = 4'b1001;
        @(negedge clk);
        expect_out("withdraw_cyc1", 4'b1000, 2'b11, 1'b1, 1'b1);
        @(negedge clk);
        expect_out("withdraw_cyc2", 4'b1000, 2'b11, 1'b1, 1'b1);
        bus.req = 4'b0001;
        @(negedge clk);
        expect_out("withdraw_gap", 4'b0000, 2'b11, 1'b0, 1'b1);
        bus.req = 4'b0000;
        @(negedge clk);
        expect_out("withdraw_idle", 4'b0000, 2'b11, 1'b0, 1'b0);

        // Fairness under req=1111: 4-cycle grants (timeout or done), 2 low cycles between
        bus.req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            idx = 2'(r % 4);
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                expect_out($sformatf("fair_g%0d_cyc%0d", r, c), 4'(1 << idx), idx, 1'b1, 1'b1);
            end
`ifndef MUX_SEL_TIMEOUT_EN
            bus.done = 1'b1;
`endif
            @(negedge clk);
            bus.done = 1'b0;
            expect_out($sformatf("fair_g%0d_gap", r), 4'b0000, idx, 1'b0, 1'b1);
            if (r == 4) bus.req = 4'b0000;
            @(negedge clk);
            expect_out($sformatf("fair_g%0d_idle", r), 4'b0000, idx, 1'b0, 1'b0);
        end

        // Long hold on channel b with done low
        bus.req = 4'b0010;
`ifdef MUX_SEL_TIMEOUT_EN
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            expect_out($sformatf("hold_to_cyc%0d", c), 4'b0010, 2'b01, 1'b1, 1'b1);
        end
`else
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            expect_out($sformatf("hold_cyc%0d", c), 4'b0010, 2'b01, 1'b1, 1'b1);
        end
`endif
        bus.req = 4'b0000;
        @(negedge clk);
        expect_out("hold_gap", 4'b0000, 2'b01, 1'b0, 1'b1);
        @(negedge clk);
        expect_out("hold_idle", 4'b0000, 2'b01, 1'b0, 1'b0);

        // Async reset mid-ACTIVE, then channel 0 has priority again
        bus.req = 4'b0100;
        @(negedge clk);
        expect_out("areset_pre", 4'b0100, 2'b10, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1 expect_out("areset_immediate", 4'b0000, 2'b00, 1'b0, 1'b0);
        bus.req = 4'b0101;
        @(negedge clk);
        expect_out("areset_held", 4'b0000, 2'b00, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        expect_out("areset_first_ch0", 4'b0001, 2'b00, 1'b1, 1'b1);
        bus.req = 4'b0000;
        @(negedge clk);
        expect_out("areset_gap", 4'b0000, 2'b00, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
